// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter onto a single-ported memory
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req_valid,
  output logic           m0_req_ready,
  input  logic [AW-1:0]  m0_addr,
  input  logic [OPW-1:0] m0_op,
  output logic           m0_resp_valid,
  input  logic           m0_resp_ready,
  output logic [DW-1:0]  m0_rdata,
  input  logic           m1_req_valid,
  output logic           m1_req_ready,
  input  logic           m1_wen,
  input  logic [AW-1:0]  m1_addr,
  input  logic [DW-1:0]  m1_wdata,
  input  logic [OPW-1:0] m1_op,
  output logic           m1_resp_valid,
  input  logic           m1_resp_ready,
  output logic [DW-1:0]  m1_rdata,
  output logic [AW-1:0]  mem_raddr,
  output logic [AW-1:0]  mem_waddr,
  output logic [DW-1:0]  mem_wdata,
  output logic [OPW-1:0] wdt_op,
  output logic           mem_ren,
  output logic           mem_wen,
  input  logic [DW-1:0]  mem_rdata,
  output logic           grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [OPW-1:0] op_q, op_d;
  logic           wen_q, wen_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic win;
  logic accept;
  logic resp_hs;
  logic in_idle, in_issue, in_resp;

  assign in_idle  = (state_q == IDLE);
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  // Round-robin pick: on contention the master not granted last wins; ready only in IDLE and never during reset
  always_comb begin
    win = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      win = ~last_grant_q;
    end else if (m1_req_valid) begin
      win = 1'b1;
    end
    m0_req_ready = ~rst & in_idle & m0_req_valid & ~win;
    m1_req_ready = ~rst & in_idle & m1_req_valid & win;
    accept       = m0_req_ready | m1_req_ready;
    resp_hs      = in_resp & (grant_q ? m1_resp_ready : m0_resp_ready);
  end

  // Next-state: latch the winner on acceptance, capture read data at the end of ISSUE, release on response handshake
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    wen_d        = wen_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ISSUE;
          grant_d      = win;
          last_grant_d = win;
          addr_d       = win ? m1_addr : m0_addr;
          wdata_d      = win ? m1_wdata : '0;
          op_d         = win ? m1_op : m0_op;
          wen_d        = win & m1_wen;
        end
      end
      ISSUE: begin
        rdata_d = wen_q ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset clears everything and makes m0 win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      wen_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      wen_q        <= wen_d;
      rdata_q      <= rdata_d;
    end
  end

  // Downstream strobes and fields are live only during the single ISSUE cycle
  always_comb begin
    mem_ren   = in_issue & ~wen_q;
    mem_wen   = in_issue & wen_q;
    mem_raddr = mem_ren ? addr_q : '0;
    mem_waddr = mem_wen ? addr_q : '0;
    mem_wdata = mem_wen ? wdata_q : '0;
    wdt_op    = in_issue ? op_q : '0;
  end

  // Response goes only to the granted master; the other sees zero data
  always_comb begin
    m0_resp_valid = in_resp & ~grant_q;
    m1_resp_valid = in_resp & grant_q;
    m0_rdata      = m0_resp_valid ? rdata_q : '0;
    m1_rdata      = m1_resp_valid ? rdata_q : '0;
    grant_id      = grant_q;
  end

endmodule
